if_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the PC register and the single-outstanding-request handshake to instruction memory.
- Owns the IF/ID pipeline register, which drives decode with pre-split instruction fields, PC and PC+4.
- Takes redirect select and targets (branch/jal/jalr) from decode and a stall from the hazard unit; inserts NOP bubbles on redirect and memory wait.

---
 rtl/if_pkg.sv | 12 +
 rtl/if_stage_if.sv | 12 +
 rtl/if_id_reg.sv | 75 +++++++
 rtl/if_stage.sv | 163 ++++++++++++++++
 tb/tb_if_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_IMM = 2'b01;
   localparam logic [1:0] PC_REG = 2'b10;

   typedef enum logic [1:0] {REQ, HOLD, DROP} fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch handshake: one outstanding request, response may be same-cycle.
interface if_stage_if #(parameter int XLEN = 32);

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            imem_valid;

   modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
   modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall holds, bubble writes a NOP, load captures a fetched word.
module if_id_reg
   import if_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            stall_i,
   input  logic            bubble_i,
   input  logic            load_i,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [24:0]     Instr31_7_o,
   output logic [6:0]      op_o,
   output logic [4:0]      rd_o,
   output logic [2:0]      funct3_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic            funct7_5_o,
   output logic [XLEN-1:0] PC_o,
   output logic [XLEN-1:0] pcPlus4_o
);

   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc4_q, pc4_d;

   // Stall beats bubble beats load: a frozen decode stage must never see its input change.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      if (!stall_i) begin
         if (bubble_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
         end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
            pc4_d   = pc_i + XLEN'(4);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         pc4_q   <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
      end
   end

   assign valid_o     = valid_q;
   assign Instr31_7_o = instr_q[31:7];
   assign op_o        = instr_q[6:0];
   assign rd_o        = instr_q[11:7];
   assign funct3_o    = instr_q[14:12];
   assign rs1_o       = instr_q[19:15];
   assign rs2_o       = instr_q[24:20];
   assign funct7_5_o  = instr_q[30];
   assign PC_o        = pc_q;
   assign pcPlus4_o   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM and IF/ID register.
// Define IF_STAGE_PERF_EN to add saturating bubble/redirect counters.
module if_stage
   import if_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            stall_i,
   input  logic [1:0]      PCsrc_i,
   input  logic [XLEN-1:0] pcPlusImm_i,
   input  logic [XLEN-1:0] regPlusImm_i,
   if_stage_if.master      imem,
   output logic            valid_o,
   output logic [24:0]     Instr31_7_o,
   output logic [6:0]      op_o,
   output logic [4:0]      rd_o,
   output logic [2:0]      funct3_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic            funct7_5_o,
   output logic [XLEN-1:0] PC_o,
   output logic [XLEN-1:0] pcPlus4_o
`ifdef IF_STAGE_PERF_EN
   ,
   output logic [31:0]     bubble_cnt_o,
   output logic [31:0]     redirect_cnt_o
`endif
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [31:0]     buf_q, buf_d;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            load, bubble;
   logic [31:0]     ld_instr;

   assign redirect = ((PCsrc_i == PC_IMM) || (PCsrc_i == PC_REG)) && !stall_i;
   assign target   = (PCsrc_i == PC_REG) ? regPlusImm_i : pcPlusImm_i;

   assign imem.imem_req  = (state_q == REQ) || (state_q == DROP);
   assign imem.imem_addr = (state_q == DROP) ? addr_q : pc_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      buf_d    = buf_q;
      load     = 1'b0;
      bubble   = 1'b0;
      ld_instr = imem.imem_rdata[31:0];
      case (state_q)
         REQ: begin
            if (stall_i) begin
               // Response cannot enter IF/ID yet; park it so the memory is free.
               if (imem.imem_valid) begin
                  buf_d   = imem.imem_rdata[31:0];
                  state_d = HOLD;
               end
            end else if (redirect) begin
               bubble = 1'b1;
               pc_d   = target;
               if (!imem.imem_valid) begin
                  addr_d  = pc_q;
                  state_d = DROP;
               end
            end else if (imem.imem_valid) begin
               load = 1'b1;
               pc_d = pc_q + XLEN'(4);
            end else begin
               bubble = 1'b1;
            end
         end
         HOLD: begin
            if (!stall_i) begin
               state_d = REQ;
               if (redirect) begin
                  bubble = 1'b1;
                  pc_d   = target;
               end else begin
                  load     = 1'b1;
                  ld_instr = buf_q;
                  pc_d     = pc_q + XLEN'(4);
               end
            end
         end
         DROP: begin
            // The stale response is garbage either way, so retire it even under stall.
            if (imem.imem_valid) state_d = REQ;
            if (!stall_i) begin
               bubble = 1'b1;
               if (redirect) pc_d = target;
            end
         end
         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         buf_q   <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
      end
   end

   if_id_reg #(.XLEN(XLEN)) u_if_id (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .stall_i     (stall_i),
      .bubble_i    (bubble),
      .load_i      (load),
      .instr_i     (ld_instr),
      .pc_i        (pc_q),
      .valid_o     (valid_o),
      .Instr31_7_o (Instr31_7_o),
      .op_o        (op_o),
      .rd_o        (rd_o),
      .funct3_o    (funct3_o),
      .rs1_o       (rs1_o),
      .rs2_o       (rs2_o),
      .funct7_5_o  (funct7_5_o),
      .PC_o        (PC_o),
      .pcPlus4_o   (pcPlus4_o)
   );

`ifdef IF_STAGE_PERF_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;

   always_comb begin
      bubble_cnt_d   = bubble_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (bubble && (bubble_cnt_q != '1))     bubble_cnt_d   = bubble_cnt_q + 32'd1;
      if (redirect && (redirect_cnt_q != '1)) redirect_cnt_d = redirect_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bubble_cnt_q   <= '0;
         redirect_cnt_q <= '0;
      end else begin
         bubble_cnt_q   <= bubble_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign bubble_cnt_o   = bubble_cnt_q;
   assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stall/redirect/latency traffic,
// checked against a program-order model of the instruction stream.
module tb_if_stage;
   import if_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        stall_i = 1'b0;
   logic [1:0]  PCsrc_i = 2'b00;
   logic [31:0] pcPlusImm_i = '0;
   logic [31:0] regPlusImm_i = '0;
   logic        valid_o;
   logic [24:0] Instr31_7_o;
   logic [6:0]  op_o;
   logic [4:0]  rd_o, rs1_o, rs2_o;
   logic [2:0]  funct3_o;
   logic        funct7_5_o;
   logic [31:0] PC_o, pcPlus4_o;
`ifdef IF_STAGE_PERF_EN
   logic [31:0] bubble_cnt_o, redirect_cnt_o;
`endif

   if_stage_if #(.XLEN(32)) imem ();

   always #5 clk_i = ~clk_i;

   if_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .stall_i      (stall_i),
      .PCsrc_i      (PCsrc_i),
      .pcPlusImm_i  (pcPlusImm_i),
      .regPlusImm_i (regPlusImm_i),
      .imem         (imem),
      .valid_o      (valid_o),
      .Instr31_7_o  (Instr31_7_o),
      .op_o         (op_o),
      .rd_o         (rd_o),
      .funct3_o     (funct3_o),
      .rs1_o        (rs1_o),
      .rs2_o        (rs2_o),
      .funct7_5_o   (funct7_5_o),
      .PC_o         (PC_o),
      .pcPlus4_o    (pcPlus4_o)
`ifdef IF_STAGE_PERF_EN
      ,
      .bubble_cnt_o   (bubble_cnt_o),
      .redirect_cnt_o (redirect_cnt_o)
`endif
   );

   int          n_tests = 0;
   int          n_fail = 0;
   int          mem_wait = -1;
   logic [31:0] mem_addr = '0;
   int          lat_lo = 0, lat_hi = 0;
   logic [31:0] exp_pc = '0;
   int          exp_bub = 0, exp_rdr = 0, n_instr = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] cur_instr();
      return {Instr31_7_o, op_o};
   endfunction

   // One clock: memory answers for this cycle, then the edge, then the stream model checks IF/ID.
   task automatic cycle();
      logic        rst, stl, rdr, s_valid;
      logic [31:0] tgt, s_instr, s_pc, s_pc4, w;
      rst = !rst_ni;
      stl = stall_i;
      rdr = !rst && !stl && (PCsrc_i == PC_IMM || PCsrc_i == PC_REG);
      tgt = (PCsrc_i == PC_REG) ? regPlusImm_i : pcPlusImm_i;
      imem.imem_valid = 1'b0;
      imem.imem_rdata = 32'hDEAD_BEEF;
      if (imem.imem_req) begin
         if (mem_wait < 0) begin
            mem_addr = imem.imem_addr;
            mem_wait = $urandom_range(lat_hi, lat_lo);
         end else begin
            check("addr_stable", imem.imem_addr, mem_addr);
         end
         if (mem_wait == 0) begin
            imem.imem_valid = 1'b1;
            imem.imem_rdata = mem_word(mem_addr);
            mem_wait = -1;
         end else begin
            mem_wait--;
         end
      end
      s_valid = valid_o; s_instr = cur_instr(); s_pc = PC_o; s_pc4 = pcPlus4_o;
      @(posedge clk_i);
      @(negedge clk_i);
      if (rst) begin
         check("rst_valid", valid_o, 0);
         check("rst_instr", cur_instr(), NOP_INSTR);
         check("rst_pc", PC_o, 0);
         check("rst_pc4", pcPlus4_o, 0);
         exp_pc = 32'h0; mem_wait = -1; exp_bub = 0; exp_rdr = 0;
      end else if (stl) begin
         check("stall_vld", valid_o, s_valid);
         check("stall_ins", cur_instr(), s_instr);
         check("stall_pc", PC_o, s_pc);
         check("stall_pc4", pcPlus4_o, s_pc4);
      end else if (rdr) begin
         check("rdr_vld", valid_o, 0);
         check("rdr_nop", cur_instr(), NOP_INSTR);
         exp_pc = tgt; exp_bub++; exp_rdr++;
      end else if (valid_o) begin
         w = mem_word(exp_pc);
         check("pc", PC_o, exp_pc);
         check("instr", cur_instr(), w);
         check("pc4", pcPlus4_o, exp_pc + 32'd4);
         check("fields", {funct7_5_o, rs2_o, rs1_o, funct3_o, rd_o},
               {w[30], w[24:20], w[19:15], w[14:12], w[11:7]});
         exp_pc = exp_pc + 32'd4; n_instr++;
      end else begin
         check("bubble_nop", cur_instr(), NOP_INSTR);
         exp_bub++;
      end
   endtask

   task automatic check_perf(input string tag);
`ifdef IF_STAGE_PERF_EN
      check({tag, "_bub"}, bubble_cnt_o, exp_bub);
      check({tag, "_rdr"}, redirect_cnt_o, exp_rdr);
`else
      if (tag.len() == 0) $display("perf disabled");
`endif
   endtask

   initial begin
      logic [31:0] pc_at_stall, old_addr;
      int          vcnt, base;
      logic        got;
      imem.imem_valid = 1'b0;
      imem.imem_rdata = '0;

      // Reset state
      rst_ni = 1'b0;
      cycle();
      cycle();
      check("rst_req", imem.imem_req, 1);
      check("rst_addr", imem.imem_addr, 0);
      check_perf("rst");

      // Zero-wait ROM: one instruction per cycle
      rst_ni = 1'b1;
      cycle();
      check("t1_valid", valid_o, 1);
      check("t1_pc0", PC_o, 0);
      check("t1_rd0", rd_o, 1);
      check("t1_op0", op_o, 7'h13);
      cycle();
      check("t1_pc1", PC_o, 4);
      check("t1_rs1", rs1_o, 0);
      check("t1_rd1", rd_o, 2);
      repeat (4) begin
         cycle();
         check("t1_tput", valid_o, 1);
      end

      // One wait cycle per fetch: alternating bubble/instruction
      lat_lo = 1; lat_hi = 1; vcnt = 0;
      repeat (6) begin
         cycle();
         if (valid_o) vcnt++;
      end
      check("t2_vld_cnt", vcnt, 3);

      // Stall while the response arrives: buffered, memory idle, then released
      lat_lo = 0; lat_hi = 0;
      pc_at_stall = imem.imem_addr;
      stall_i = 1'b1;
      cycle();
      check("t3_req_hold", imem.imem_req, 0);
      cycle();
      cycle();
      check("t3_req_hold2", imem.imem_req, 0);
      stall_i = 1'b0;
      cycle();
      check("t3_buf_vld", valid_o, 1);
      check("t3_buf_pc", PC_o, pc_at_stall);
      cycle();
      check("t3_next_pc", PC_o, pc_at_stall + 32'd4);

      // Redirect while a request is outstanding: late response dropped
      lat_lo = 3; lat_hi = 3;
      cycle();
      old_addr = imem.imem_addr;
      PCsrc_i = PC_IMM; pcPlusImm_i = 32'h40;
      cycle();
      PCsrc_i = PC_SEQ;
      check("t4_drop_req", imem.imem_req, 1);
      check("t4_drop_addr", imem.imem_addr, old_addr);
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         cycle();
         if (valid_o) got = 1'b1;
      end
      check("t4_got", got, 1);
      check("t4_pc", PC_o, 32'h40);

      // jalr redirect with zero-wait memory; reserved select acts sequential
      lat_lo = 0; lat_hi = 0;
      cycle();
      PCsrc_i = PC_REG; regPlusImm_i = 32'h100;
      cycle();
      PCsrc_i = 2'b11; pcPlusImm_i = 32'h800; regPlusImm_i = 32'h900;
      cycle();
      check("t5_pc", PC_o, 32'h100);
      PCsrc_i = PC_SEQ;
      cycle();
      check("t5_seq", PC_o, 32'h104);
      check_perf("t5");

      // Reset while in DROP
      lat_lo = 3; lat_hi = 3;
      cycle();
      PCsrc_i = PC_IMM; pcPlusImm_i = 32'h200;
      cycle();
      PCsrc_i = PC_SEQ;
      rst_ni = 1'b0;
      cycle();
      rst_ni = 1'b1;
      check("t6_req", imem.imem_req, 1);
      check("t6_addr", imem.imem_addr, 0);
      check_perf("t6");

      // Random stall/redirect/latency traffic
      lat_lo = 0; lat_hi = 2;
      base = n_instr;
      for (int i = 0; i < 3000; i++) begin
         stall_i = ($urandom_range(4, 0) == 0);
         PCsrc_i = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : PC_SEQ;
         pcPlusImm_i  = {20'h0, 10'($urandom_range(1023, 0)), 2'b00};
         regPlusImm_i = {20'h0, 10'($urandom_range(1023, 0)), 2'b00};
         cycle();
      end
      stall_i = 1'b0; PCsrc_i = PC_SEQ;
      check("rand_progress", (n_instr - base > 500) ? 1 : 0, 1);
      check_perf("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
